// File: rtl/mips_pkg.sv
// Shared MIPS pipeline types and constants used by the instruction-fetch stage.
package mips_pkg;

  localparam int PC_W = 32;
  localparam logic [PC_W-1:0] WORD_BYTES = 32'd4;
  localparam logic [31:0] NOP_INSTR_DEFAULT = 32'h0000_0000;

  typedef enum logic [1:0] {
    BOOT   = 2'd0,
    RUN    = 2'd1,
    HOLD   = 2'd2,
    SQUASH = 2'd3
  } fetch_state_t;

  // Successor state; identical from every state, which keeps the FSM a pure function of this edge's controls.
  function automatic fetch_state_t next_fetch_state(input logic pcsrc, input logic stall);
    if (pcsrc) return SQUASH;
    else if (stall) return HOLD;
    else return RUN;
  endfunction

endpackage

// File: rtl/if_id_latch.sv
// IF/ID pipeline register: npc, instruction and valid with hold and squash controls.
module if_id_latch
  import mips_pkg::*;
#(
  parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEFAULT
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            hold,
  input  logic            squash,
  input  logic [PC_W-1:0] d_npc,
  input  logic [31:0]     d_instr,
  output logic [PC_W-1:0] npc,
  output logic [31:0]     instr,
  output logic            valid
);

  // Squash outranks hold so a taken branch can never be frozen behind a stall.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      npc   <= '0;
      instr <= NOP_INSTR;
      valid <= 1'b0;
    end else if (squash) begin
      npc   <= d_npc;
      instr <= NOP_INSTR;
      valid <= 1'b0;
    end else if (!hold) begin
      npc   <= d_npc;
      instr <= d_instr;
      valid <= 1'b1;
    end
  end

endmodule

// File: rtl/if_fetch_unit.sv
// MIPS instruction-fetch stage: PC register, PC+4 incrementer, fetch FSM and IF/ID latch.
// Optional macro IF_ALIGN_CHECK_EN: misaligned branch targets fall through and raise misalign_err.
module if_fetch_unit
  import mips_pkg::*;
#(
  parameter logic [PC_W-1:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0]     NOP_INSTR = NOP_INSTR_DEFAULT
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            stall,
  input  logic            pcsrc,
  input  logic [PC_W-1:0] branch_target,
  input  logic [31:0]     imem_data,
  output logic [PC_W-1:0] imem_addr,
  output logic [PC_W-1:0] if_id_npc,
  output logic [31:0]     if_id_instr,
  output logic            if_id_valid,
  output logic [1:0]      fetch_state
`ifdef IF_ALIGN_CHECK_EN
  ,
  output logic            misalign_err
`endif
);

  // Control contract: pcsrc and stall are level signals sampled on every rising edge;
  // pcsrc wins over stall, and there is no backpressure from this stage upstream.
  fetch_state_t    state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic [PC_W-1:0] npc;
  logic [PC_W-1:0] redirect_pc;
  logic            latch_hold;
  logic            latch_squash;

  assign npc = pc_q + WORD_BYTES;

`ifdef IF_ALIGN_CHECK_EN
  logic misaligned;
  logic misalign_q;

  assign misaligned  = (branch_target[1:0] != 2'b00);
  assign redirect_pc = misaligned ? npc : branch_target;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) misalign_q <= 1'b0;
    else        misalign_q <= pcsrc && misaligned;
  end

  assign misalign_err = misalign_q;
`else
  assign redirect_pc = branch_target;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= BOOT;
      pc_q    <= RESET_PC;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
    end
  end

  always_comb begin
    state_d      = next_fetch_state(pcsrc, stall);
    pc_d         = pc_q;
    latch_hold   = 1'b0;
    latch_squash = 1'b0;
    if (pcsrc) begin
      pc_d         = redirect_pc;
      latch_squash = 1'b1;
    end else if (stall) begin
      latch_hold = 1'b1;
    end else begin
      pc_d = npc;
    end
  end

  if_id_latch #(
    .NOP_INSTR(NOP_INSTR)
  ) u_if_id (
    .clk    (clk),
    .rst_n  (rst_n),
    .hold   (latch_hold),
    .squash (latch_squash),
    .d_npc  (npc),
    .d_instr(imem_data),
    .npc    (if_id_npc),
    .instr  (if_id_instr),
    .valid  (if_id_valid)
  );

  assign imem_addr   = pc_q;
  assign fetch_state = state_q;

endmodule
